// File: rtl/inst_fetcher_pkg.sv
// Shared fetch-stage types and constants: instruction/register words,
// queue entry layout, FSM encoding and the JALR opcode decode.
package inst_fetcher_pkg;

    typedef logic [31:0] inst_t;
    typedef logic [31:0] reg_t;

    localparam int unsigned OPCODE_LO          = 0;
    localparam int unsigned OPCODE_HI          = 6;
    localparam logic [6:0]  OPCODE_JALR        = 7'b1100111;
    localparam int unsigned DEFAULT_QUEUE_SIZE = 8;

    typedef struct packed {
        inst_t inst;
        reg_t  pc;
        reg_t  pred_pc;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_WAIT,
        FS_DISCARD
    } fetch_state_t;

    function automatic logic is_jalr(input inst_t inst);
        return inst[OPCODE_HI:OPCODE_LO] == OPCODE_JALR;
    endfunction

endpackage

// File: rtl/inst_fetcher_queue.sv
// Circular FIFO of fetched instructions with synchronous clear and a global
// enable; pointers wrap naturally because DEPTH is a power of two.
module inst_queue
    import inst_fetcher_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_QUEUE_SIZE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en_i,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  fetch_entry_t               data_i,
    input  logic                       pop_i,
    output fetch_entry_t               data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;
    logic             full, do_push, do_pop;

    always_comb begin
        full    = (count_q == CNT_W'(DEPTH));
        empty_o = (count_q == '0);
        do_push = push_i && !full;
        do_pop  = pop_i && !empty_o;
        data_o  = mem_q[head_q];
        count_o = count_q;
    end

    always_ff @(posedge clk) begin
        if (en_i && !clear_i && do_push) begin
            mem_q[tail_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (en_i) begin
            if (clear_i) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (do_push) tail_q <= tail_q + 1'b1;
                if (do_pop)  head_q <= head_q + 1'b1;
                if (do_push && !do_pop) begin
                    count_q <= count_q + 1'b1;
                end else if (do_pop && !do_push) begin
                    count_q <= count_q - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetch stage: one outstanding icache request, pc register,
// ROB flush handling. Define FETCH_JALR_STALL_EN to halt fetch after a JALR.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int unsigned INST_QUEUE_SIZE = DEFAULT_QUEUE_SIZE,
    parameter logic [31:0] RESET_PC        = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        valid_to_icache,
    output logic [31:0] pc_to_icache,
    input  logic        valid_from_icache,
    input  logic [31:0] inst_from_icache,
    output logic [31:0] inst_to_br_predictor,
    output logic [31:0] pc_to_br_predictor,
    input  logic [31:0] next_pc_from_br_predictor,
    output logic        valid_to_issuer,
    output logic [31:0] inst_to_issuer,
    output logic [31:0] pc_to_issuer,
    output logic [31:0] pred_pc_to_issuer,
    input  logic        ready_from_issuer,
    input  logic        reset_valid_from_rob_bus,
    input  logic [31:0] reset_pc_from_rob_bus
);

    localparam int unsigned CNT_W = $clog2(INST_QUEUE_SIZE) + 1;

    fetch_state_t     state_q;
    reg_t             pc_q;
    logic             halt_q;
    logic             req_q;

    logic [CNT_W-1:0] q_count;
    logic             q_empty;
    fetch_entry_t     q_head;
    fetch_entry_t     push_data_d;
    logic             push_d, pop_d, room_d;

    always_comb begin
        room_d      = (q_count < CNT_W'(INST_QUEUE_SIZE));
        push_d      = (state_q == FS_WAIT) && valid_from_icache && !reset_valid_from_rob_bus;
        pop_d       = ready_from_issuer && !q_empty;
        push_data_d = '{inst: inst_from_icache, pc: pc_q, pred_pc: next_pc_from_br_predictor};
    end

    inst_queue #(
        .DEPTH (INST_QUEUE_SIZE)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .en_i    (rdy),
        .clear_i (reset_valid_from_rob_bus),
        .push_i  (push_d),
        .data_i  (push_data_d),
        .pop_i   (pop_d),
        .data_o  (q_head),
        .count_o (q_count),
        .empty_o (q_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FS_IDLE;
            pc_q    <= RESET_PC;
            halt_q  <= 1'b0;
            req_q   <= 1'b0;
        end else if (rdy) begin
            if (reset_valid_from_rob_bus) begin
                pc_q   <= reset_pc_from_rob_bus;
                halt_q <= 1'b0;
                req_q  <= 1'b0;
                // An outstanding request whose response has not yet arrived must be drained.
                if (state_q != FS_IDLE && !valid_from_icache) begin
                    state_q <= FS_DISCARD;
                end else begin
                    state_q <= FS_IDLE;
                end
            end else begin
                case (state_q)
                    FS_IDLE: begin
                        if (room_d && !halt_q) begin
                            req_q   <= 1'b1;
                            state_q <= FS_WAIT;
                        end
                    end
                    FS_WAIT: begin
                        if (valid_from_icache) begin
                            pc_q    <= next_pc_from_br_predictor;
                            req_q   <= 1'b0;
                            state_q <= FS_IDLE;
`ifdef FETCH_JALR_STALL_EN
                            if (is_jalr(inst_from_icache)) halt_q <= 1'b1;
`endif
                        end
                    end
                    FS_DISCARD: begin
                        if (valid_from_icache) state_q <= FS_IDLE;
                    end
                    default: state_q <= FS_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        valid_to_icache      = req_q;
        pc_to_icache         = pc_q;
        inst_to_br_predictor = inst_from_icache;
        pc_to_br_predictor   = pc_q;
        valid_to_issuer      = !q_empty;
        inst_to_issuer       = q_head.inst;
        pc_to_issuer         = q_head.pc;
        pred_pc_to_issuer    = q_head.pred_pc;
    end

endmodule

// File: tb/tb_inst_fetcher.sv
// Scoreboard bench for inst_fetcher: icache responses push expected queue
// entries, issuer pops compare them; honours FETCH_JALR_STALL_EN.
module tb_inst_fetcher;
    import inst_fetcher_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        valid_to_icache;
    logic [31:0] pc_to_icache;
    logic        valid_from_icache;
    logic [31:0] inst_from_icache;
    logic [31:0] inst_to_br_predictor, pc_to_br_predictor;
    logic [31:0] next_pc_from_br_predictor;
    logic        valid_to_issuer;
    logic [31:0] inst_to_issuer, pc_to_issuer, pred_pc_to_issuer;
    logic        ready_from_issuer;
    logic        reset_valid_from_rob_bus;
    logic [31:0] reset_pc_from_rob_bus;

    int          errors = 0;
    int          checks = 0;
    fetch_entry_t sb[$];
    logic [31:0] exp_pc;

    inst_fetcher #(
        .INST_QUEUE_SIZE (8),
        .RESET_PC        (32'h0)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .rdy                       (rdy),
        .valid_to_icache           (valid_to_icache),
        .pc_to_icache              (pc_to_icache),
        .valid_from_icache         (valid_from_icache),
        .inst_from_icache          (inst_from_icache),
        .inst_to_br_predictor      (inst_to_br_predictor),
        .pc_to_br_predictor        (pc_to_br_predictor),
        .next_pc_from_br_predictor (next_pc_from_br_predictor),
        .valid_to_issuer           (valid_to_issuer),
        .inst_to_issuer            (inst_to_issuer),
        .pc_to_issuer              (pc_to_issuer),
        .pred_pc_to_issuer         (pred_pc_to_issuer),
        .ready_from_issuer         (ready_from_issuer),
        .reset_valid_from_rob_bus  (reset_valid_from_rob_bus),
        .reset_pc_from_rob_bus     (reset_pc_from_rob_bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input int unsigned budget, output bit got);
        got = 1'b0;
        for (int unsigned i = 0; i < budget; i++) begin
            if (valid_to_icache === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Icache model: answer the pending request; optionally pop the head in the same cycle.
    task automatic icache_respond(input logic [31:0] inst, input logic [31:0] pred, input bit also_pop);
        bit           got;
        fetch_entry_t e;
        wait_req(20, got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL req_timeout: valid_to_icache=%b required 1 (pc %h)", valid_to_icache, exp_pc);
            return;
        end
        checks++;
        if (pc_to_icache !== exp_pc) begin
            errors++;
            $display("FAIL req_pc: pc_to_icache=%h required %h", pc_to_icache, exp_pc);
        end
        valid_from_icache         = 1'b1;
        inst_from_icache          = inst;
        next_pc_from_br_predictor = pred;
        if (also_pop) begin
            ready_from_issuer = 1'b1;
            checks++;
            if (sb.size() == 0 || valid_to_issuer !== 1'b1) begin
                errors++;
                $display("FAIL simul_pop: valid_to_issuer=%b sb_size=%0d required valid head", valid_to_issuer, sb.size());
            end else begin
                e = sb.pop_front();
                if ({inst_to_issuer, pc_to_issuer, pred_pc_to_issuer} !== {e.inst, e.pc, e.pred_pc}) begin
                    errors++;
                    $display("FAIL simul_head: got %h/%h/%h required %h/%h/%h", inst_to_issuer, pc_to_issuer,
                             pred_pc_to_issuer, e.inst, e.pc, e.pred_pc);
                end
            end
        end
        #1;
        checks++;
        if (pc_to_br_predictor !== exp_pc || inst_to_br_predictor !== inst) begin
            errors++;
            $display("FAIL br_pred_ports: pc=%h inst=%h required pc=%h inst=%h", pc_to_br_predictor,
                     inst_to_br_predictor, exp_pc, inst);
        end
        e.inst    = inst;
        e.pc      = exp_pc;
        e.pred_pc = pred;
        sb.push_back(e);
        exp_pc = pred;
        tick();
        valid_from_icache = 1'b0;
        ready_from_issuer = 1'b0;
    endtask

    // Issuer model: accept every head while valid, comparing each against the scoreboard.
    task automatic issuer_drain(input int unsigned budget);
        fetch_entry_t e;
        ready_from_issuer = 1'b1;
        for (int unsigned i = 0; i < budget && valid_to_issuer === 1'b1; i++) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL extra_entry: head %h/%h/%h required empty queue", inst_to_issuer, pc_to_issuer,
                         pred_pc_to_issuer);
            end else begin
                e = sb.pop_front();
                if ({inst_to_issuer, pc_to_issuer, pred_pc_to_issuer} !== {e.inst, e.pc, e.pred_pc}) begin
                    errors++;
                    $display("FAIL head: got %h/%h/%h required %h/%h/%h", inst_to_issuer, pc_to_issuer,
                             pred_pc_to_issuer, e.inst, e.pc, e.pred_pc);
                end
            end
            tick();
        end
        ready_from_issuer = 1'b0;
        checks++;
        if (sb.size() != 0 || valid_to_issuer !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: sb_left=%0d valid_to_issuer=%b required 0/0", sb.size(), valid_to_issuer);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rdy = 1'b1;
        valid_from_icache         = 1'b0;
        inst_from_icache          = '0;
        next_pc_from_br_predictor = '0;
        ready_from_issuer         = 1'b0;
        reset_valid_from_rob_bus  = 1'b1;
        reset_pc_from_rob_bus     = 32'hDEAD_0000;
        repeat (3) tick();
        checks++;
        if (valid_to_icache !== 1'b0 || valid_to_issuer !== 1'b0 || pc_to_icache !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: req=%b valid=%b pc=%h required 0/0/00000000", valid_to_icache,
                     valid_to_issuer, pc_to_icache);
        end
        rst = 1'b0;
        reset_valid_from_rob_bus = 1'b0;
        exp_pc = 32'h0;
    endtask

    task automatic test_first_fetch();
        bit got;
        icache_respond(32'h0000_0013, 32'h4, 1'b0);
        wait_req(20, got);
        checks++;
        if (!got || pc_to_icache !== 32'h4) begin
            errors++;
            $display("FAIL second_req: req=%b pc=%h required 1/00000004", valid_to_icache, pc_to_icache);
        end
        issuer_drain(4);
    endtask

    task automatic test_jal();
        bit got;
        icache_respond(32'h0000_0013, 32'h8, 1'b0);
        icache_respond(32'h0080_006F, 32'h10, 1'b0);
        wait_req(20, got);
        checks++;
        if (!got || pc_to_icache !== 32'h10) begin
            errors++;
            $display("FAIL jal_target: req=%b pc=%h required 1/00000010", valid_to_icache, pc_to_icache);
        end
        issuer_drain(4);
    endtask

    task automatic test_full();
        bit           stalled_ok;
        fetch_entry_t e;
        for (int unsigned i = 0; i < 8; i++) begin
            icache_respond(32'h0000_0013 | (i << 20), exp_pc + 32'h4, 1'b0);
        end
        stalled_ok = 1'b1;
        for (int unsigned i = 0; i < 6; i++) begin
            if (valid_to_icache !== 1'b0) stalled_ok = 1'b0;
            tick();
        end
        checks++;
        if (!stalled_ok || valid_to_issuer !== 1'b1) begin
            errors++;
            $display("FAIL full_stall: req_seen=%b valid=%b required 0/1", !stalled_ok, valid_to_issuer);
        end
        ready_from_issuer = 1'b1;
        e = sb.pop_front();
        checks++;
        if ({inst_to_issuer, pc_to_issuer, pred_pc_to_issuer} !== {e.inst, e.pc, e.pred_pc}) begin
            errors++;
            $display("FAIL full_pop: got %h/%h/%h required %h/%h/%h", inst_to_issuer, pc_to_issuer,
                     pred_pc_to_issuer, e.inst, e.pc, e.pred_pc);
        end
        tick();
        ready_from_issuer = 1'b0;
        icache_respond(32'h0090_0013, exp_pc + 32'h4, 1'b0);
        issuer_drain(12);
    endtask

    task automatic test_rdy_freeze();
        bit           got;
        fetch_entry_t e;
        icache_respond(32'h0010_0093, exp_pc + 32'h4, 1'b0);
        wait_req(20, got);
        rdy                      = 1'b0;
        ready_from_issuer        = 1'b1;
        reset_valid_from_rob_bus = 1'b1;
        reset_pc_from_rob_bus    = 32'h300;
        repeat (4) tick();
        e = sb[0];
        checks++;
        if (valid_to_issuer !== 1'b1 || {inst_to_issuer, pc_to_issuer} !== {e.inst, e.pc}) begin
            errors++;
            $display("FAIL freeze_queue: valid=%b head %h/%h required 1 %h/%h", valid_to_issuer, inst_to_issuer,
                     pc_to_issuer, e.inst, e.pc);
        end
        checks++;
        if (valid_to_icache !== 1'b1 || pc_to_icache !== exp_pc) begin
            errors++;
            $display("FAIL freeze_req: req=%b pc=%h required 1/%h", valid_to_icache, pc_to_icache, exp_pc);
        end
        reset_valid_from_rob_bus = 1'b0;
        ready_from_issuer        = 1'b0;
        rdy                      = 1'b1;
        issuer_drain(4);
    endtask

    task automatic test_back_to_back();
        for (int unsigned i = 0; i < 3; i++) begin
            icache_respond(32'h0020_0013 | (i << 7), exp_pc + 32'h4, 1'b0);
        end
        for (int unsigned i = 0; i < 10; i++) begin
            icache_respond(32'h0030_0013 | (i << 7), exp_pc + 32'h4, 1'b1);
        end
        issuer_drain(8);
    endtask

    task automatic test_flush_wait();
        bit got;
        bit leak;
        icache_respond(32'h0040_0013, exp_pc + 32'h4, 1'b0);
        icache_respond(32'h0050_0013, exp_pc + 32'h4, 1'b0);
        wait_req(20, got);
        reset_valid_from_rob_bus = 1'b1;
        reset_pc_from_rob_bus    = 32'h100;
        tick();
        reset_valid_from_rob_bus = 1'b0;
        sb.delete();
        checks++;
        if (valid_to_issuer !== 1'b0 || valid_to_icache !== 1'b0) begin
            errors++;
            $display("FAIL flush_state: valid=%b req=%b required 0/0", valid_to_issuer, valid_to_icache);
        end
        valid_from_icache         = 1'b1;
        inst_from_icache          = 32'hDEAD_BEEF;
        next_pc_from_br_predictor = 32'h500;
        tick();
        valid_from_icache = 1'b0;
        leak = 1'b0;
        for (int unsigned i = 0; i < 2; i++) begin
            if (valid_to_issuer !== 1'b0) leak = 1'b1;
            tick();
        end
        checks++;
        if (leak) begin
            errors++;
            $display("FAIL stale_dropped: valid_to_issuer=1 required 0");
        end
        exp_pc = 32'h100;
        icache_respond(32'h0060_0013, 32'h104, 1'b0);
        issuer_drain(4);
    endtask

    task automatic test_flush_with_resp();
        bit got;
        wait_req(20, got);
        valid_from_icache         = 1'b1;
        inst_from_icache          = 32'hBAD0_0013;
        next_pc_from_br_predictor = 32'h900;
        reset_valid_from_rob_bus  = 1'b1;
        reset_pc_from_rob_bus     = 32'h180;
        tick();
        valid_from_icache        = 1'b0;
        reset_valid_from_rob_bus = 1'b0;
        checks++;
        if (valid_to_issuer !== 1'b0) begin
            errors++;
            $display("FAIL flush_resp_drop: valid_to_issuer=%b required 0", valid_to_issuer);
        end
        exp_pc = 32'h180;
        icache_respond(32'h0070_0013, 32'h184, 1'b0);
        issuer_drain(4);
    endtask

    task automatic test_jalr();
        bit          got;
        logic [31:0] jalr_pc;
        jalr_pc = exp_pc;
        icache_respond(32'h0000_80E7, jalr_pc + 32'h4, 1'b0);
        issuer_drain(4);
`ifdef FETCH_JALR_STALL_EN
        wait_req(10, got);
        checks++;
        if (got) begin
            errors++;
            $display("FAIL jalr_halt: req=%b pc=%h required no request", valid_to_icache, pc_to_icache);
        end
        reset_valid_from_rob_bus = 1'b1;
        reset_pc_from_rob_bus    = 32'h200;
        tick();
        reset_valid_from_rob_bus = 1'b0;
        exp_pc = 32'h200;
        icache_respond(32'h0000_0013, 32'h204, 1'b0);
        issuer_drain(4);
`else
        wait_req(20, got);
        checks++;
        if (!got || pc_to_icache !== jalr_pc + 32'h4) begin
            errors++;
            $display("FAIL jalr_continue: req=%b pc=%h required 1/%h", valid_to_icache, pc_to_icache,
                     jalr_pc + 32'h4);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_jal();
        test_full();
        test_rdy_freeze();
        test_back_to_back();
        test_flush_wait();
        test_flush_with_resp();
        test_jalr();
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
